// File: rtl/mult_share_arbiter_if.sv
// Bundle between the sharing arbiter, its client requesters and the single
// shared sequential multiplier. The arbiter uses the slave view.
interface mult_share_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req_i;
  logic [N*W-1:0] a_bi;
  logic [N*W-1:0] b_bi;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   done_o;
  logic [2*W-1:0] y_bo;
  logic           busy_o;
  logic           mul_start_o;
  logic [W-1:0]   mul_a_bo;
  logic [W-1:0]   mul_b_bo;
  logic [2*W-1:0] mul_y_bi;
  logic           mul_busy_i;

  modport slave (
    input  req_i, a_bi, b_bi, mul_y_bi, mul_busy_i,
    output gnt_o, done_o, y_bo, busy_o, mul_start_o, mul_a_bo, mul_b_bo
  );

  modport master (
    output req_i, a_bi, b_bi, mul_y_bi, mul_busy_i,
    input  gnt_o, done_o, y_bo, busy_o, mul_start_o, mul_a_bo, mul_b_bo
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one start/busy sequential multiplier among N
// requesters; latches the winner's operands and returns the product with done.
module mult_share_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mult_share_arbiter_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  win_q, win_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   mul_a_q, mul_a_d;
  logic [W-1:0]   mul_b_q, mul_b_d;
  logic [2*W-1:0] y_q, y_d;

  logic           found;
  logic [IW-1:0]  pick;

  // First set request searching upward from the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.req_i[(int'(rr_q) + i) % N]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + i) % N);
      end
    end
  end

  // NOTE: non-blocking assignments keep every register update in the same
  // edge independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    // NOTE: defaulting every next-state value to its register first means no
    // branch can leave one unassigned, so no latches are inferred.
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        // A multiplier still running after an arbiter reset must drain first.
        if (found && !bus.mul_busy_i) begin
          win_d   = pick;
          gnt_d   = N'(1) << pick;
          mul_a_d = bus.a_bi[int'(pick)*W +: W];
          mul_b_d = bus.b_bi[int'(pick)*W +: W];
          state_d = ISSUE;
        end
      end
      ISSUE:  state_d = SETTLE;
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (!bus.mul_busy_i) begin
          y_d     = bus.mul_y_bi;
          state_d = RESP;
        end
      end
      RESP: begin
        gnt_d   = '0;
        rr_d    = (int'(win_q) == N - 1) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_o       = gnt_q;
    bus.done_o      = (state_q == RESP) ? gnt_q : '0;
    bus.y_bo        = y_q;
    bus.busy_o      = (state_q != IDLE);
    bus.mul_start_o = (state_q == ISSUE);
    bus.mul_a_bo    = mul_a_q;
    bus.mul_b_bo    = mul_b_q;
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a 9-cycle-busy multiplier model
// whose result reads 0xDEAD until busy falls.
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int YW = 2 * W;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mult_share_arbiter_if #(.N(N), .W(W)) bus ();
  mult_share_arbiter #(.N(N), .W(W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Multiplier model: busy rises the cycle after start, stays high 9 cycles.
  int            m_cnt = 0;
  logic [W-1:0]  m_pa  = '0;
  logic [W-1:0]  m_pb  = '0;
  logic [YW-1:0] m_y   = '0;

  always @(posedge clk_i) begin
    if (bus.mul_start_o) begin
      m_pa  <= bus.mul_a_bo;
      m_pb  <= bus.mul_b_bo;
      m_cnt <= 9;
      m_y   <= 16'hDEAD;
    end else if (m_cnt == 1) begin
      m_cnt <= 0;
      m_y   <= YW'(m_pa) * YW'(m_pb);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign bus.mul_busy_i = (m_cnt != 0);
  assign bus.mul_y_bi   = m_y;

  task automatic set_op(input int k, input int a, input int b);
    bus.a_bi[k*W +: W] = W'(a);
    bus.b_bi[k*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // Called in the grant (t0) cycle; steps cycles until done_o, bounded.
  task automatic run_op(output int widx, output logic [YW-1:0] y, output int lat,
                        output int starts, output int busy_cyc, output logic [N-1:0] gnt1);
    widx = -1; y = '0; lat = 0; starts = 0; busy_cyc = 0; gnt1 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) gnt1 = bus.gnt_o;
      if (bus.mul_start_o) starts++;
      if (bus.busy_o) busy_cyc++;
      if (bus.done_o != '0) begin
        for (int k = 0; k < N; k++) if (bus.done_o[k]) widx = k;
        if ($countones(bus.done_o) != 1) widx = -2;
        y   = bus.y_bo;
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_i = '0; bus.a_bi = '0; bus.b_bi = '0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    total++; if (bus.gnt_o !== '0)       begin bad++; $display("FAIL reset_gnt got=%h want=0", bus.gnt_o); end
    total++; if (bus.done_o !== '0)      begin bad++; $display("FAIL reset_done got=%h want=0", bus.done_o); end
    total++; if (bus.y_bo !== '0)        begin bad++; $display("FAIL reset_y got=%h want=0", bus.y_bo); end
    total++; if (bus.busy_o !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.mul_start_o !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", bus.mul_start_o); end
    total++; if (bus.mul_a_bo !== '0)    begin bad++; $display("FAIL reset_mul_a got=%h want=0", bus.mul_a_bo); end
    total++; if (bus.mul_b_bo !== '0)    begin bad++; $display("FAIL reset_mul_b got=%h want=0", bus.mul_b_bo); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single();
    int widx, lat, starts, busy_cyc;
    logic [YW-1:0] y;
    logic [N-1:0] gnt1;
    set_op(0, 13, 11);
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL single_busy_t0 got=%b want=0", bus.busy_o); end
    bus.req_i = 4'b0001;
    run_op(widx, y, lat, starts, busy_cyc, gnt1);
    bus.req_i = '0;
    total++; if (gnt1 !== 4'b0001)  begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt1); end
    total++; if (starts != 1)       begin bad++; $display("FAIL single_starts got=%0d want=1", starts); end
    total++; if (lat != 12)         begin bad++; $display("FAIL single_latency got=%0d want=12", lat); end
    total++; if (busy_cyc != 12)    begin bad++; $display("FAIL single_busy_cycles got=%0d want=12", busy_cyc); end
    total++; if (widx != 0)         begin bad++; $display("FAIL single_done_idx got=%0d want=0", widx); end
    total++; if (y !== 16'd143)     begin bad++; $display("FAIL single_y got=%0d want=143", y); end
    @(posedge clk_i); #1;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", bus.busy_o); end
    total++; if (bus.gnt_o !== '0)    begin bad++; $display("FAIL single_gnt_after got=%b want=0", bus.gnt_o); end
    total++; if (bus.y_bo !== 16'd143) begin bad++; $display("FAIL single_y_held got=%0d want=143", bus.y_bo); end
  endtask

  task automatic test_all_four();
    int widx, lat, starts, busy_cyc;
    logic [YW-1:0] y;
    logic [N-1:0] gnt1;
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, k + 1, k + 2);
    bus.req_i = 4'b1111;
    for (int r = 0; r < 2 * N; r++) begin
      run_op(widx, y, lat, starts, busy_cyc, gnt1);
      total++; if (widx != r % N) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", r, widx, r % N); end
      total++; if (y !== YW'(((r % N) + 1) * ((r % N) + 2)))
        begin bad++; $display("FAIL rr_y[%0d] got=%0d want=%0d", r, y, ((r % N) + 1) * ((r % N) + 2)); end
      total++; if (starts != 1) begin bad++; $display("FAIL rr_starts[%0d] got=%0d want=1", r, starts); end
    end
    bus.req_i = '0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_hold_extra();
    int widx, lat, starts, busy_cyc;
    logic [YW-1:0] y;
    logic [N-1:0] gnt1;
    set_op(2, 5, 6);
    set_op(1, 3, 7);
    bus.req_i = 4'b0100;
    run_op(widx, y, lat, starts, busy_cyc, gnt1);
    total++; if (widx != 2 || y !== 16'd30) begin bad++; $display("FAIL hold_first got=%0d/%0d want=2/30", widx, y); end
    bus.req_i = 4'b0110;
    run_op(widx, y, lat, starts, busy_cyc, gnt1);
    total++; if (widx != 1 || y !== 16'd21) begin bad++; $display("FAIL hold_wrap got=%0d/%0d want=1/21", widx, y); end
    bus.req_i = 4'b0100;
    run_op(widx, y, lat, starts, busy_cyc, gnt1);
    total++; if (widx != 2 || y !== 16'd30) begin bad++; $display("FAIL hold_reserve got=%0d/%0d want=2/30", widx, y); end
    bus.req_i = '0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_operand_change();
    int widx = -1;
    logic [YW-1:0] y = '0;
    set_op(3, 255, 255);
    bus.req_i = 4'b1000;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_i); #1;
      if (c == 5) set_op(3, 0, 255);
      if (c == 6) begin
        total++; if (bus.mul_a_bo !== 8'd255) begin bad++; $display("FAIL opchg_mul_a got=%0d want=255", bus.mul_a_bo); end
      end
      if (bus.done_o != '0) begin
        for (int k = 0; k < N; k++) if (bus.done_o[k]) widx = k;
        y = bus.y_bo;
        break;
      end
    end
    bus.req_i = '0;
    total++; if (widx != 3)        begin bad++; $display("FAIL opchg_idx got=%0d want=3", widx); end
    total++; if (y !== 16'd65025)  begin bad++; $display("FAIL opchg_y got=%0d want=65025", y); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    int widx = -1;
    logic [YW-1:0] y = '0;
    logic prev_busy, early, granted;
    logic [N-1:0] prev_gnt;
    set_op(0, 7, 9);
    bus.req_i = 4'b0001;
    repeat (5) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    #1;
    total++; if (bus.gnt_o !== '0 || bus.done_o !== '0 || bus.busy_o !== 1'b0 || bus.mul_start_o !== 1'b0)
      begin bad++; $display("FAIL midrst_ctrl got=gnt%b done%b busy%b start%b want=all0", bus.gnt_o, bus.done_o, bus.busy_o, bus.mul_start_o); end
    total++; if (bus.mul_a_bo !== '0 || bus.mul_b_bo !== '0 || bus.y_bo !== '0)
      begin bad++; $display("FAIL midrst_data got=a%h b%h y%h want=all0", bus.mul_a_bo, bus.mul_b_bo, bus.y_bo); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    set_op(0, 6, 7);
    prev_busy = bus.mul_busy_i; prev_gnt = bus.gnt_o; early = 1'b0; granted = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_i); #1;
      if (bus.gnt_o != '0 && prev_gnt == '0) begin
        granted = 1'b1;
        if (prev_busy) early = 1'b1;
      end
      prev_busy = bus.mul_busy_i;
      prev_gnt  = bus.gnt_o;
      if (bus.done_o != '0) begin
        for (int k = 0; k < N; k++) if (bus.done_o[k]) widx = k;
        y = bus.y_bo;
        break;
      end
    end
    bus.req_i = '0;
    total++; if (early !== 1'b0 || granted !== 1'b1)
      begin bad++; $display("FAIL midrst_grant_wait got=early%b granted%b want=early0 granted1", early, granted); end
    total++; if (widx != 0)      begin bad++; $display("FAIL midrst_idx got=%0d want=0", widx); end
    total++; if (y !== 16'd42)   begin bad++; $display("FAIL midrst_y got=%0d want=42", y); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_boundary();
    int widx, lat, starts, busy_cyc;
    logic [YW-1:0] y;
    logic [N-1:0] gnt1;
    set_op(1, 0, 0);
    bus.req_i = 4'b0010;
    run_op(widx, y, lat, starts, busy_cyc, gnt1);
    bus.req_i = '0;
    total++; if (widx != 1 || y !== 16'd0) begin bad++; $display("FAIL bnd_zero got=%0d/%0d want=1/0", widx, y); end
    total++; if (lat != 12 || starts != 1 || busy_cyc != 12)
      begin bad++; $display("FAIL bnd_zero_timing got=lat%0d st%0d busy%0d want=12/1/12", lat, starts, busy_cyc); end
    @(posedge clk_i); #1;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL bnd_busy_low got=%b want=0", bus.busy_o); end
    set_op(2, 255, 1);
    bus.req_i = 4'b0100;
    run_op(widx, y, lat, starts, busy_cyc, gnt1);
    bus.req_i = '0;
    total++; if (gnt1 !== 4'b0100) begin bad++; $display("FAIL bnd_max_gnt got=%b want=0100", gnt1); end
    total++; if (widx != 2 || y !== 16'd255) begin bad++; $display("FAIL bnd_max got=%0d/%0d want=2/255", widx, y); end
    total++; if (lat != 12 || starts != 1 || busy_cyc != 12)
      begin bad++; $display("FAIL bnd_max_timing got=lat%0d st%0d busy%0d want=12/1/12", lat, starts, busy_cyc); end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_hold_extra();
    test_operand_change();
    test_reset_mid();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one sequential 8x8 shift-add multiplier (start/busy handshake) among N requesters with round-robin arbitration.
- Latches the winner's operands and issues a one-cycle start pulse to the multiplier.
- Waits for the multiplier to finish, then returns the 16-bit product to the winner with a one-cycle done pulse.
- Sits between client FSMs (for example, two hypotenuse-style units) and a single multiplier instance.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand width; the product is 2*W bits wide.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  N  per-requester request level.
- a_bi  in  N*W  packed operand A; requester k uses bits [k*W +: W].
- b_bi  in  N*W  packed operand B, same packing as a_bi.
- gnt_o  out  N  one-hot grant; high from ISSUE through RESP.
- done_o  out  N  one-hot, one-cycle pulse; result valid for that requester.
- y_bo  out  2W  product; valid while done_o is nonzero, held afterwards.
- busy_o  out  1  high whenever state is not IDLE.
- mul_start_o  out  1  start pulse to the multiplier.
- mul_a_bo  out  W  operand A to the multiplier (registered).
- mul_b_bo  out  W  operand B to the multiplier (registered).
- mul_y_bi  in  2W  multiplier result.
- mul_busy_i  in  1  multiplier busy.

Behaviour:
- Reset (async, active-high): state=IDLE; rr pointer=0; gnt_o=0, done_o=0, y_bo=0, mul_start_o=0, mul_a_bo=0, mul_b_bo=0, busy_o=0. Reset mid-operation aborts immediately with no done_o for the aborted request.
- States: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE:
  - If req_i != 0 and mul_busy_i == 0, select the winner: the first set bit of req_i searching from index rr upward, wrapping modulo N.
  - Latch the winner's operands into mul_a_bo/mul_b_bo, set gnt_o = one-hot(winner), go to ISSUE.
  - If mul_busy_i == 1 (for example, a multiplier still running after an arbiter reset), stay in IDLE.
- ISSUE: mul_start_o = 1 for exactly this cycle; go to SETTLE.
- SETTLE: one cycle that covers the multiplier's one-cycle delay before busy rises. mul_busy_i is ignored here. Go to WAIT.
- WAIT: while mul_busy_i == 1, stay. When mul_busy_i == 0, capture y_bo <= mul_y_bi and go to RESP.
- RESP:
  - done_o = one-hot(winner) for this one cycle; gnt_o stays held.
  - On exit: gnt_o <= 0, rr <= (winner+1) mod N, go to IDLE.
- Requester contract:
  - Hold req_i and operands stable from assertion until done_o.
  - Drop req_i on the clock edge that ends the done_o cycle, i.e. at the RESP->IDLE transition.
  - A req_i still high in the following IDLE cycle is a new request and is served again, at lowest priority.
  - Operands are sampled only in IDLE at grant; later changes do not affect the current operation.
- Fairness: the served requester becomes lowest priority, so with all N requesting, grants cycle 0,1,...,N-1,0.
- Latency with a multiplier whose busy stays high 9 cycles: IDLE grant cycle = t0; ISSUE t1; SETTLE t2; WAIT t3..t11; done_o high at t12.
- Requests arriving while not in IDLE are not lost: they are evaluated at the next IDLE.
- busy_o = (state != IDLE). At most one operation is outstanding.
- Widths: no truncation; y_bo is 2W bits and is copied verbatim from mul_y_bi.

Test Plan:
- Reset, then req_i=0001 with A0=13, B0=11 -> gnt_o=0001 at t0+1; one mul_start_o pulse at t1; done_o=0001 at t12; y_bo=143.
- All four request simultaneously, operands k+1 x k+2 -> done order 0,1,2,3 with y_bo 2,6,12,20. Repeat with req held -> order continues 0,1,2,3 (rr wrap).
- req_i=0100 alone served; req[2] held one extra cycle after done while req[1] rises in the same IDLE -> requester 1 wins (rr=3 wraps to 0, then 1), then 2 is re-served.
- Operand change during WAIT (A3 from 255 to 0; A3=B3=255 at grant) -> y_bo=65025 (uses the latched operand).
- Assert rst_i during WAIT -> all outputs 0 immediately, no done_o. With model mul_busy_i still high after reset, a new req_i is not granted until mul_busy_i falls; then the correct product is returned.
- Boundary operands: 0x0 -> 0; 255x1 -> 255. Check busy_o high exactly from t1 through t12 and mul_start_o high for exactly one cycle per grant.
